// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - write, dual read and bulk-clear bus for param_register_file
interface param_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wData;
  logic              rEnA;
  logic [ADDR_W-1:0] rAddrA;
  logic [DATA_W-1:0] rDataA;
  logic              rValidA;
  logic              rEnB;
  logic [ADDR_W-1:0] rAddrB;
  logic [DATA_W-1:0] rDataB;
  logic              rValidB;
  logic              clr;
  logic              busy;

  modport master (
    output we, wAddr, wData, rEnA, rAddrA, rEnB, rAddrB, clr,
    input  rDataA, rValidA, rDataB, rValidB, busy
  );

  modport slave (
    input  we, wAddr, wData, rEnA, rAddrA, rEnB, rAddrB, clr,
    output rDataA, rValidA, rDataB, rValidB, busy
  );
endinterface

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised 2-read register file with bypass and bulk clear
// Optional: PARAM_REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module param_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  param_register_file_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] nxt_a, nxt_b;
  logic              busy, we_eff, wr_ok;

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;
  assign we_eff   = bus.we & ~busy;

`ifdef PARAM_REGFILE_ZERO_REG_EN
  assign wr_ok = we_eff & (bus.wAddr != '0);
`else
  assign wr_ok = we_eff;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes are gated by busy, so the clear and a write never target storage together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[bus.wAddr] <= bus.wData;
    end
  end

  // Clear-bypass overrides write-bypass; entry 0 needs no override since wr_ok already excludes it.
  always_comb begin
    nxt_a = mem[bus.rAddrA];
    if (wr_ok && bus.wAddr == bus.rAddrA) nxt_a = bus.wData;
    if (busy && bus.rAddrA == cnt) nxt_a = '0;
  end

  always_comb begin
    nxt_b = mem[bus.rAddrB];
    if (wr_ok && bus.wAddr == bus.rAddrB) nxt_b = bus.wData;
    if (busy && bus.rAddrB == cnt) nxt_b = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rDataA  <= '0;
      bus.rValidA <= 1'b0;
      bus.rDataB  <= '0;
      bus.rValidB <= 1'b0;
    end else begin
      bus.rValidA <= bus.rEnA;
      bus.rValidB <= bus.rEnB;
      if (bus.rEnA) bus.rDataA <= nxt_a;
      if (bus.rEnB) bus.rDataB <= nxt_b;
    end
  end
endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - randomized self-checking bench for param_register_file
module tb_param_register_file;
  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef PARAM_REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  param_register_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  param_register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left;
  logic [DW-1:0] exp_a, exp_b;
  logic          exp_va, exp_vb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("rValidA", 64'(bus.rValidA), 64'(exp_va));
    check("rDataA",  64'(bus.rDataA),  64'(exp_a));
    check("rValidB", 64'(bus.rValidB), 64'(exp_vb));
    check("rDataB",  64'(bus.rDataB),  64'(exp_b));
    check("busy",    64'(bus.busy),    64'(clear_left > 0));
  endtask

  task automatic drive(input bit we, input int wa, input logic [DW-1:0] wd,
                       input bit ea, input int aa, input bit eb, input int ab, input bit c);
    bus.we = we; bus.wAddr = AW'(wa); bus.wData = wd;
    bus.rEnA = ea; bus.rAddrA = AW'(aa);
    bus.rEnB = eb; bus.rAddrB = AW'(ab);
    bus.clr = c;
  endtask

  function automatic logic [DW-1:0] model_read(input int a, input bit wr);
    int pos = DEPTH - clear_left;
    if (clear_left > 0 && a == pos) return '0;
    if (ZERO && a == 0) return '0;
    if (wr && int'(bus.wAddr) == a) return bus.wData;
    return mem_m[a];
  endfunction

  task automatic step();
    bit clearing = (clear_left > 0);
    bit wr = bus.we && !clearing && !(ZERO && bus.wAddr == '0);
    logic [DW-1:0] va = model_read(int'(bus.rAddrA), wr);
    logic [DW-1:0] vb = model_read(int'(bus.rAddrB), wr);
    exp_va = bus.rEnA;
    exp_vb = bus.rEnB;
    if (bus.rEnA) exp_a = va;
    if (bus.rEnB) exp_b = vb;
    if (clearing) begin
      mem_m[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (wr) mem_m[bus.wAddr] = bus.wData;
      if (bus.clr) clear_left = DEPTH;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    clear_left = 0;
    exp_a = '0; exp_b = '0; exp_va = 1'b0; exp_vb = 1'b0;
    check_outputs();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int busy_cycles;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    #2;
    apply_reset();

    drive(0, 0, '0, 1, 5, 0, 0, 0); step();
    check("reset_read_data", 64'(bus.rDataA), 64'h0);
    check("reset_read_valid", 64'(bus.rValidA), 64'h1);
    drive(0, 0, '0, 0, 0, 0, 0, 0); step();
    check("hold_valid_low", 64'(bus.rValidA), 64'h0);

    drive(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0); step();
    drive(0, 0, '0, 1, 3, 1, 3, 0); step();
    check("dual_read_a", 64'(bus.rDataA), 64'hDEADBEEF);
    check("dual_read_b", 64'(bus.rDataB), 64'hDEADBEEF);

    drive(0, 0, '0, 0, 0, 1, 6, 0); step();
    check("old_value_b", 64'(bus.rDataB), 64'h0);
    drive(1, 6, 32'h12345678, 1, 6, 0, 0, 0); step();
    check("write_bypass", 64'(bus.rDataA), 64'h12345678);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, DW'(32'h11 * (i + 1)), 0, 0, 0, 0, 0); step();
    end
    drive(0, 0, '0, 0, 0, 0, 0, 1); step();
    busy_cycles = 0;
    for (int k = 0; k < 3 * DEPTH && bus.busy; k++) begin
      busy_cycles++;
      drive(k == 0, 2, 32'hFFFFFFFF, k == DEPTH - 1, DEPTH - 1, 1, k, 0);
      step();
      if (k == DEPTH - 1) check("clear_bypass", 64'(bus.rDataA), 64'h0);
    end
    check("busy_cycles", 64'(busy_cycles), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, '0, 1, i, 1, DEPTH - 1 - i, 0); step();
      check("cleared_entry", 64'(bus.rDataA), 64'h0);
    end

    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i, $urandom, 0, 0, 0, 0, 0); step();
    end
    drive(0, 0, '0, 0, 0, 0, 0, 1); step();
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    apply_reset();
    check("busy_after_reset", 64'(bus.busy), 64'h0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, '0, 1, i, 1, i, 0); step();
      check("post_reset_zero", 64'(bus.rDataB), 64'h0);
    end
    drive(1, 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0); step();
    drive(0, 0, '0, 1, 1, 0, 0, 0); step();
    check("post_reset_write", 64'(bus.rDataA), 64'hA5A5A5A5);

    drive(1, 0, 32'hCAFEF00D, 1, 0, 0, 0, 0); step();
    check("zero_reg_bypass", 64'(bus.rDataA), ZERO ? 64'h0 : 64'hCAFEF00D);
    drive(0, 0, '0, 1, 0, 1, 0, 0); step();
    check("zero_reg_read", 64'(bus.rDataB), ZERO ? 64'h0 : 64'hCAFEF00D);

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 1),
            $urandom_range(0, 19) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
